// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready flow control and an optional two-entry skid buffer.
// It supports flush, bubble gating of write-enable/halt, a sticky halt-seen flag and sticky protocol-error detection.
module pipe_stage_buf #(
  parameter int DW   = 16,
  parameter int NCH  = 5,
  parameter int CW   = 7,
  parameter int RW   = 3,
  parameter int SKID = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [CW-1:0]     in_ctrl,
  input  logic              in_wreg,
  input  logic [RW-1:0]     in_rd,
  input  logic              in_halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NCH*DW-1:0] out_data,
  output logic [CW-1:0]     out_ctrl,
  output logic              out_wreg,
  output logic [RW-1:0]     out_rd,
  output logic              out_halt,
  output logic              halt_seen,
  output logic              err
);

  localparam int PW = NCH * DW;

  typedef struct packed {
    logic [PW-1:0] data;
    logic [CW-1:0] ctrl;
    logic          wreg;
    logic [RW-1:0] rd;
    logic          halt;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  entry_t        main_reg, skid_reg, in_entry;
  logic          ready_base_reg;
  logic          halt_seen_reg, err_reg, stalled_prev_reg;
  logic [PW-1:0] data_prev_reg;
  logic [RW-1:0] rd_prev_reg;
  logic          xfer_in, xfer_out;
  logic          load_main_in, load_main_skid, load_skid_in;
  logic [NCH-1:0] chan_changed;
  logic          withdrew;

  always_comb begin
    in_entry      = '0;
    in_entry.data = in_data;
    in_entry.ctrl = in_ctrl;
    in_entry.wreg = in_wreg;
    in_entry.rd   = in_rd;
    in_entry.halt = in_halt;
  end

  // With the skid entry, in_ready is purely registered; without it, it looks through to out_ready.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = ready_base_reg;
    end else begin : g_single_ready
      assign in_ready = ready_base_reg & (~out_valid | out_ready);
    end
  endgenerate

  assign out_valid = (state_reg != ST_EMPTY);
  assign out_data  = main_reg.data;
  assign out_ctrl  = main_reg.ctrl;
  assign out_rd    = main_reg.rd;
  assign out_wreg  = main_reg.wreg & out_valid;
  assign out_halt  = main_reg.halt & out_valid;
  assign halt_seen = halt_seen_reg;
  assign err       = err_reg;

  assign xfer_in  = in_valid & in_ready;
  assign xfer_out = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= ST_EMPTY;
      ready_base_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ready_base_reg <= (SKID != 0) ? (state_next != ST_FULL) : 1'b1;
    end
  end

  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        if (xfer_in) begin
          state_next   = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (xfer_in && xfer_out) begin
          load_main_in = 1'b1;
        end else if (xfer_in) begin
          if (SKID != 0) begin
            state_next   = ST_FULL;
            load_skid_in = 1'b1;
          end else begin
            load_main_in = 1'b1;
          end
        end else if (xfer_out) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (xfer_out) begin
          state_next     = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
    // Flush overrides any handshake in the same cycle.
    if (flush) begin
      state_next     = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_reg <= '0;
      skid_reg <= '0;
    end else begin
      if (load_main_in) begin
        main_reg <= in_entry;
      end else if (load_main_skid) begin
        main_reg <= skid_reg;
      end
      if (load_skid_in) begin
        skid_reg <= in_entry;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan_cmp
      assign chan_changed[gi] = (in_data[gi*DW +: DW] != data_prev_reg[gi*DW +: DW]);
    end
  endgenerate

  // A stalled offer must be held unchanged until accepted.
  assign withdrew = stalled_prev_reg & (~in_valid | (|chan_changed) | (in_rd != rd_prev_reg));

  always_ff @(posedge clk) begin
    if (!rst) begin
      halt_seen_reg    <= 1'b0;
      err_reg          <= 1'b0;
      stalled_prev_reg <= 1'b0;
      data_prev_reg    <= '0;
      rd_prev_reg      <= '0;
    end else begin
      halt_seen_reg    <= halt_seen_reg | (xfer_out & out_halt & ~flush);
      err_reg          <= err_reg | withdrew;
      stalled_prev_reg <= in_valid & ~in_ready & ~flush;
      data_prev_reg    <= in_data;
      rd_prev_reg      <= in_rd;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed, table-driven checks of pipe_stage_buf: reset, streaming, stall, flush, halt/bubble, protocol error.
module tb_pipe_stage_buf;
  localparam int DW  = 16;
  localparam int NCH = 5;
  localparam int CW  = 7;
  localparam int RW  = 3;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_wreg, in_halt, out_ready;
  logic [NCH*DW-1:0] in_data;
  logic [CW-1:0]     in_ctrl;
  logic [RW-1:0]     in_rd;

  logic              in_ready, out_valid, out_wreg, out_halt, halt_seen, err;
  logic [NCH*DW-1:0] out_data;
  logic [CW-1:0]     out_ctrl;
  logic [RW-1:0]     out_rd;

  logic              in_ready0, out_valid0, out_wreg0, out_halt0, halt_seen0, err0;
  logic [NCH*DW-1:0] out_data0;
  logic [CW-1:0]     out_ctrl0;
  logic [RW-1:0]     out_rd0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DW(DW), .NCH(NCH), .CW(CW), .RW(RW), .SKID(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wreg(in_wreg), .in_rd(in_rd), .in_halt(in_halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .out_wreg(out_wreg), .out_rd(out_rd), .out_halt(out_halt), .halt_seen(halt_seen), .err(err)
  );

  pipe_stage_buf #(.DW(DW), .NCH(NCH), .CW(CW), .RW(RW), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wreg(in_wreg), .in_rd(in_rd), .in_halt(in_halt),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_ctrl(out_ctrl0),
    .out_wreg(out_wreg0), .out_rd(out_rd0), .out_halt(out_halt0), .halt_seen(halt_seen0), .err(err0)
  );

  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic        wreg, halt, ordy, fl;
    logic        ov, ir;
    logic [15:0] od;
    logic        owreg, ohalt, hs, er;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [NCH*DW-1:0] rep(input logic [15:0] v);
    return {NCH{v}};
  endfunction

  function automatic vec_t mk(input logic iv, input logic [15:0] d, input logic wreg, input logic halt,
                              input logic ordy, input logic fl, input logic ov, input logic ir,
                              input logic [15:0] od, input logic owreg, input logic ohalt,
                              input logic hs, input logic er);
    vec_t v;
    v.iv = iv; v.d = d; v.wreg = wreg; v.halt = halt; v.ordy = ordy; v.fl = fl;
    v.ov = ov; v.ir = ir; v.od = od; v.owreg = owreg; v.ohalt = ohalt; v.hs = hs; v.er = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] d, input logic wreg, input logic halt,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = rep(d);
    in_ctrl   = d[6:0];
    in_rd     = d[2:0];
    in_wreg   = wreg;
    in_halt   = halt;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [15:0] VA = 16'h0A01;
  localparam logic [15:0] VB = 16'h0B02;
  localparam logic [15:0] VC = 16'h0C03;
  localparam logic [15:0] VD = 16'h0D04;
  localparam logic [15:0] VH = 16'h0E05;

  initial begin
    logic [15:0] dv;
    rst = 1'b0;
    drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset held two cycles with in_valid asserted
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_in_ready_skid0", in_ready0, 0);
    chk("rst_err", err, 0);
    chk("rst_halt_seen", halt_seen, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b1;
    step();
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);
    step();
    chk("first_out_valid", out_valid, 1);
    chk("first_out_data", out_data, rep(16'h1234));
    chk("first_err", err, 0);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("first_drain", out_valid, 0);

    // Streaming: eight back-to-back entries through both variants
    for (int i = 0; i < 8; i++) begin
      dv = 16'(i);
      drive(1'b1, dv, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      chk($sformatf("stream%0d_ov", i), out_valid, 1);
      chk($sformatf("stream%0d_data", i), out_data, rep(dv));
      chk($sformatf("stream%0d_ir", i), in_ready, 1);
      chk($sformatf("stream%0d_ov_s0", i), out_valid0, 1);
      chk($sformatf("stream%0d_data_s0", i), out_data0, rep(dv));
      chk($sformatf("stream%0d_ir_s0", i), in_ready0, 1);
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("stream_end_ov", out_valid, 0);
    chk("stream_end_ov_s0", out_valid0, 0);

    // Stall/skid, flush, halt/bubble sequence on the skid variant
    //           iv    d   wreg  halt  ordy  fl  | ov   ir   od   owreg ohalt hs   err
    tbl[0]  = mk(1'b1, VA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, VA, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, VB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, VA, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, VC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, VA, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b1, VC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, VA, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, VC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, VB, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, VC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, VC, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, VC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, VC, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(1'b1, VA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, VA, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, VB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, VA, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk(1'b1, VC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, VC, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, VD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, VD, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, VD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, VD, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk(1'b1, VH, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, VH, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[13] = mk(1'b0, VH, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, VH, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk(1'b1, VH, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, VH, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[15] = mk(1'b0, VH, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, VH, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[16] = mk(1'b0, VH, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, VH, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[17] = mk(1'b0, VH, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, VH, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].wreg, tbl[i].halt, tbl[i].ordy, tbl[i].fl);
      step();
      chk($sformatf("row%0d_out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("row%0d_in_ready", i), in_ready, tbl[i].ir);
      chk($sformatf("row%0d_out_wreg", i), out_wreg, tbl[i].owreg);
      chk($sformatf("row%0d_out_halt", i), out_halt, tbl[i].ohalt);
      chk($sformatf("row%0d_halt_seen", i), halt_seen, tbl[i].hs);
      chk($sformatf("row%0d_err", i), err, tbl[i].er);
      if (tbl[i].ov) begin
        chk($sformatf("row%0d_out_data", i), out_data, rep(tbl[i].od));
        chk($sformatf("row%0d_out_ctrl", i), out_ctrl, tbl[i].od[6:0]);
        chk($sformatf("row%0d_out_rd", i), out_rd, tbl[i].od[2:0]);
      end
    end

    // Protocol error: stalled offer withdrawn before acceptance
    drive(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("proto_full_ir", in_ready, 0);
    drive(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("proto_stalled_err", err, 0);
    drive(1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("proto_withdraw_err", err, 1);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); step(); step();
    chk("proto_err_sticky", err, 1);
    chk("proto_drained", out_valid, 0);
    rst = 1'b0;
    step();
    chk("proto_rst_err", err, 0);
    chk("proto_rst_ir", in_ready, 0);
    chk("proto_rst_halt_seen", halt_seen, 0);
    rst = 1'b1;
    step();
    chk("proto_rel_ir", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
